aes_job_sequencer: RTL and testbench
====================================

Name: aes_job_sequencer

Overview:
- Parametrised successor to the fixed-key AES top-level control. Accepts 128-bit blocks over a valid/ready handshake, each tagged with key size (128/192/256) and direction (encrypt/decrypt).
- Sequences an external single-round AES engine through rounds 0..Nr, one round per cycle, with the correct round-key index.
- Buffers results with their tags in an output FIFO. Key size and mode are per-job, so switching neither stalls nor flushes in-flight work.

Parameters:
- DATA_W, 128, block width in bits.
- TAG_W, 4, user tag width, carried unchanged from input to output.
- OUT_DEPTH, 4, output FIFO depth in entries; power of two, ≥2.
- CNT_W, 16, width of the completed-job counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  job offered.
- in_ready  out  1  sequencer can accept a job.
- in_data  in  DATA_W  input block.
- in_keysel  in  2  00=128-bit (Nr=10), 01=192-bit (Nr=12), 10/11=256-bit (Nr=14).
- in_decrypt  in  1  0=encrypt, 1=decrypt.
- in_tag  in  TAG_W  user tag.
- eng_state  out  DATA_W  current state presented to the round engine.
- eng_round  out  4  round step 0..Nr.
- eng_key_idx  out  4  round-key index: encrypt = eng_round; decrypt = Nr − eng_round.
- eng_first  out  1  eng_round==0 (AddRoundKey only).
- eng_last  out  1  eng_round==Nr (no MixColumns).
- eng_decrypt  out  1  latched direction of the current job.
- eng_keysel  out  2  latched key size of the current job.
- eng_result  in  DATA_W  combinational engine output for eng_state/eng_round.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts the head entry.
- out_data  out  DATA_W  head entry result.
- out_tag  out  TAG_W  head entry tag.
- out_decrypt  out  1  head entry direction.
- busy  out  1  state != IDLE.
- jobs_done  out  CNT_W  completed jobs; wraps modulo 2^CNT_W.

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - State IDLE; FIFO emptied; round counter and jobs_done cleared to 0.
  - out_valid=0, in_ready=1 (state is IDLE), busy=0, eng_* outputs all 0.
  - Reset during RUN or STALL discards the in-flight job and all FIFO contents; no partial result is ever emitted.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch in_data into the state register, latch keysel/decrypt/tag, set round=0, go to RUN.
  - RUN: in_ready=0. Each cycle with round<Nr: state_reg<=eng_result, round<=round+1.
    - At round==Nr: if push is allowed, push {eng_result, tag, decrypt}, increment jobs_done, go to IDLE; else go to STALL.
  - STALL: state_reg and round frozen, so the engine inputs are unchanged and eng_result is stable. Push when allowed, then go to IDLE.
- Push allowed when fifo_count<OUT_DEPTH, or when the FIFO is full and a pop occurs in the same cycle (simultaneous push/pop at full is legal; count is unchanged).
- Latency:
  - Accept at edge E.
  - Engine steps 0..Nr occupy cycles E+1..E+Nr+1.
  - out_valid rises after edge E+Nr+1 (FIFO empty, consumer idle).
  - in_ready returns high after the same edge.
  - Minimum spacing between accepts is Nr+2 cycles.
- Nr is decoded from the latched keysel only. Changes to in_keysel, in_decrypt or in_tag after accept have no effect on the running job.
- in_data is sampled only on an accept edge. in_valid with in_ready=0 is ignored; no internal queueing on the input side.
- FIFO behaviour:
  - Read-first ordering; out_data/out_tag/out_decrypt are driven combinationally from the head entry.
  - Pop on out_valid&&out_ready.
  - Head entry is stable while out_valid&&!out_ready.
  - Pointers wrap modulo OUT_DEPTH.
  - Pop when empty is a no-op.
- eng_first/eng_last/eng_key_idx are combinational from the round counter and latched Nr/direction. They are held at 0 in IDLE.
- jobs_done increments on the push edge; it wraps from 2^CNT_W−1 to 0.

Test Plan:
All scenarios use a bench stub engine: eng_result = eng_state + 1.
- Encrypt, keysel=00, in_data=0, tag=3 → out_valid after 11 cycles; out_data=0x0B, out_tag=3, out_decrypt=0; eng_key_idx steps 0..10; jobs_done=1.
- Decrypt, keysel=01, in_data=0x10 → out_data=0x1D after 13 cycles; eng_key_idx sequence 12,11..0; eng_first only on the first step, eng_last only on the last.
- keysel=10 and then 11, in_data=0 each → out_data=0x0F both times; Nr=14 confirmed. Toggling in_keysel mid-job leaves the result unchanged.
- out_ready=0, issue 5 keysel=00 jobs with tags 0..4 → 4 entries buffered; the 5th job enters STALL with busy=1 and in_ready=0. Raise out_ready for one cycle → the 5th job pushes in the same cycle the head pops; tags drain in order 0,1,2,3,4.
- Assert reset at round 5 of a job with 2 FIFO entries pending → next cycle out_valid=0, busy=0, in_ready=1, jobs_done=0; the next job completes normally.
- CNT_W=4 build, 17 back-to-back jobs → jobs_done reads 1 (wrap from 15 to 0 observed); accept spacing is exactly Nr+2 cycles.

Source files
------------

// File: rtl/aes_job_sequencer_if.sv
// Job, round-engine and result-FIFO signal bundle for aes_job_sequencer.
// The slave modport is the sequencer side; master is the job source / engine / consumer side.
interface aes_job_sequencer_if #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned TAG_W  = 4,
  parameter int unsigned CNT_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [1:0]        in_keysel;
  logic              in_decrypt;
  logic [TAG_W-1:0]  in_tag;

  logic [DATA_W-1:0] eng_state;
  logic [3:0]        eng_round;
  logic [3:0]        eng_key_idx;
  logic              eng_first;
  logic              eng_last;
  logic              eng_decrypt;
  logic [1:0]        eng_keysel;
  logic [DATA_W-1:0] eng_result;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [TAG_W-1:0]  out_tag;
  logic              out_decrypt;

  logic              busy;
  logic [CNT_W-1:0]  jobs_done;

  modport slave (
    input  in_valid, in_data, in_keysel, in_decrypt, in_tag, eng_result, out_ready,
    output in_ready, eng_state, eng_round, eng_key_idx, eng_first, eng_last,
           eng_decrypt, eng_keysel, out_valid, out_data, out_tag, out_decrypt,
           busy, jobs_done
  );

  modport master (
    output in_valid, in_data, in_keysel, in_decrypt, in_tag, eng_result, out_ready,
    input  in_ready, eng_state, eng_round, eng_key_idx, eng_first, eng_last,
           eng_decrypt, eng_keysel, out_valid, out_data, out_tag, out_decrypt,
           busy, jobs_done
  );
endinterface

// File: rtl/aes_job_sequencer.sv
// Per-job AES round sequencer: steps an external single-round engine through
// rounds 0..Nr for each accepted block and queues tagged results in an output FIFO.
module aes_job_sequencer #(
  parameter int unsigned DATA_W    = 128,
  parameter int unsigned TAG_W     = 4,
  parameter int unsigned OUT_DEPTH = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  aes_job_sequencer_if.slave   bus
);
  localparam int unsigned PTR_W   = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int unsigned FCNT_W  = PTR_W + 1;
  localparam int unsigned ROUND_W = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_STALL = 2'd2
  } state_e;

  state_e             r_state;
  state_e             w_state_nxt;

  logic [DATA_W-1:0]  r_blk;
  logic [ROUND_W-1:0] r_round;
  logic [1:0]         r_keysel;
  logic               r_decrypt;
  logic [TAG_W-1:0]   r_tag;

  logic [DATA_W-1:0]  r_mem_data [OUT_DEPTH];
  logic [TAG_W-1:0]   r_mem_tag  [OUT_DEPTH];
  logic               r_mem_dec  [OUT_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [FCNT_W-1:0]  r_fifo_cnt;
  logic [CNT_W-1:0]   r_jobs_done;

  logic [ROUND_W-1:0] w_nr;
  logic               w_idle;
  logic               w_at_last;
  logic               w_fifo_empty;
  logic               w_fifo_full;
  logic               w_pop;
  logic               w_push_ok;
  logic               w_accept;
  logic               w_advance;
  logic               w_push;

  // Round count comes only from the latched key size of the running job
  always_comb begin
    case (r_keysel)
      2'b00:   w_nr = ROUND_W'(10);
      2'b01:   w_nr = ROUND_W'(12);
      default: w_nr = ROUND_W'(14);
    endcase
  end

  assign w_idle       = (r_state == S_IDLE);
  assign w_at_last    = (r_round == w_nr);
  assign w_fifo_empty = (r_fifo_cnt == '0);
  assign w_fifo_full  = (r_fifo_cnt == FCNT_W'(OUT_DEPTH));
  assign w_pop        = !w_fifo_empty && bus.out_ready;
  // A full FIFO still takes a push when its head leaves on the same edge
  assign w_push_ok    = !w_fifo_full || w_pop;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_advance   = 1'b0;
    w_push      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (!w_at_last) begin
          w_advance = 1'b1;
        end else if (w_push_ok) begin
          w_push      = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_STALL;
        end
      end
      S_STALL: begin
        if (w_push_ok) begin
          w_push      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Job context and running block state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_blk     <= '0;
      r_round   <= '0;
      r_keysel  <= '0;
      r_decrypt <= 1'b0;
      r_tag     <= '0;
    end else if (w_accept) begin
      r_blk     <= bus.in_data;
      r_round   <= '0;
      r_keysel  <= bus.in_keysel;
      r_decrypt <= bus.in_decrypt;
      r_tag     <= bus.in_tag;
    end else if (w_advance) begin
      r_blk     <= bus.eng_result;
      r_round   <= r_round + ROUND_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_fifo_cnt  <= '0;
      r_jobs_done <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr    <= r_wr_ptr + PTR_W'(1);
        r_jobs_done <= r_jobs_done + CNT_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + FCNT_W'(1);
        2'b01:   r_fifo_cnt <= r_fifo_cnt - FCNT_W'(1);
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible through r_fifo_cnt
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= bus.eng_result;
      r_mem_tag[r_wr_ptr]  <= r_tag;
      r_mem_dec[r_wr_ptr]  <= r_decrypt;
    end
  end

  assign bus.in_ready    = w_idle;
  assign bus.busy        = !w_idle;
  assign bus.jobs_done   = r_jobs_done;

  assign bus.eng_state   = w_idle ? '0 : r_blk;
  assign bus.eng_round   = w_idle ? '0 : r_round;
  assign bus.eng_key_idx = w_idle ? '0 : (r_decrypt ? (w_nr - r_round) : r_round);
  assign bus.eng_first   = !w_idle && (r_round == '0);
  assign bus.eng_last    = !w_idle && w_at_last;
  assign bus.eng_decrypt = !w_idle && r_decrypt;
  assign bus.eng_keysel  = w_idle ? 2'b00 : r_keysel;

  assign bus.out_valid   = !w_fifo_empty;
  assign bus.out_data    = r_mem_data[r_rd_ptr];
  assign bus.out_tag     = r_mem_tag[r_rd_ptr];
  assign bus.out_decrypt = r_mem_dec[r_rd_ptr];
endmodule

// File: tb/tb_aes_job_sequencer.sv
// Bench for aes_job_sequencer: stub engine (state+1), directed vectors,
// multi-cycle corner sequences and a randomized run against a queue-based model.
module tb_aes_job_sequencer;
  localparam int unsigned DATA_W    = 128;
  localparam int unsigned TAG_W     = 4;
  localparam int unsigned OUT_DEPTH = 4;
  localparam int unsigned CNT_W     = 4;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  aes_job_sequencer_if #(.DATA_W(DATA_W), .TAG_W(TAG_W), .CNT_W(CNT_W)) bus ();

  aes_job_sequencer #(
    .DATA_W(DATA_W), .TAG_W(TAG_W), .OUT_DEPTH(OUT_DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  assign bus.eng_result = bus.eng_state + DATA_W'(1);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]   keysel;
    logic         dec;
    logic [127:0] data;
    logic [3:0]   tag;
    logic [127:0] exp_data;
    int           nr;
  } vec_t;

  typedef struct {
    logic [127:0] data;
    logic [3:0]   tag;
    logic         dec;
  } ent_t;

  vec_t vecs [6];
  ent_t q [$];
  int   acc_cyc [$];

  int   m_done;
  bit   m_pend;
  int   m_start;
  int   m_nr;
  ent_t m_ent;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int nr_of(input logic [1:0] ks);
    if (ks == 2'b00) return 10;
    if (ks == 2'b01) return 12;
    return 14;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!bus.in_ready && n < 64) begin
      tick();
      n++;
    end
    check(name, 128'(n >= 64), 128'd0);
  endtask

  task automatic issue(input logic [1:0] ks, input logic dec, input logic [127:0] d,
                       input logic [3:0] tg);
    wait_ready("accept_timeout");
    bus.in_valid   = 1'b1;
    bus.in_keysel  = ks;
    bus.in_decrypt = dec;
    bus.in_data    = d;
    bus.in_tag     = tg;
    tick();
    bus.in_valid   = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.in_keysel  = 2'b00;
    bus.in_decrypt = 1'b0;
    bus.in_tag     = '0;
    bus.out_ready  = 1'b0;
    @(negedge clk);
    tick();

    // reset state
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_eng_state", bus.eng_state, 0);
    check("rst_eng_round", bus.eng_round, 0);
    check("rst_eng_key_idx", bus.eng_key_idx, 0);
    check("rst_eng_first", bus.eng_first, 0);
    check("rst_jobs_done", bus.jobs_done, 0);
    reset = 1'b0;
    tick();

    // directed vectors, one job each, result held in FIFO for inspection
    vecs[0] = '{2'b00, 1'b0, 128'h0, 4'd3, 128'h0B, 10};
    vecs[1] = '{2'b01, 1'b1, 128'h10, 4'd7, 128'h1D, 12};
    vecs[2] = '{2'b10, 1'b0, 128'h0, 4'd9, 128'h0F, 14};
    vecs[3] = '{2'b11, 1'b1, 128'h0, 4'd12, 128'h0F, 14};
    vecs[4] = '{2'b00, 1'b1, {128{1'b1}}, 4'd15, 128'h0A, 10};
    vecs[5] = '{2'b01, 1'b0, 128'h1234, 4'd5, 128'h1241, 12};
    for (int v = 0; v < 6; v++) begin
      bus.out_ready  = 1'b0;
      bus.in_valid   = 1'b1;
      bus.in_keysel  = vecs[v].keysel;
      bus.in_decrypt = vecs[v].dec;
      bus.in_data    = vecs[v].data;
      bus.in_tag     = vecs[v].tag;
      tick();
      bus.in_valid   = 1'b0;
      for (int s = 0; s <= vecs[v].nr; s++) begin
        check("vec_eng_round", bus.eng_round, 128'(s));
        check("vec_key_idx", bus.eng_key_idx,
              128'(vecs[v].dec ? vecs[v].nr - s : s));
        check("vec_eng_first", bus.eng_first, 128'(s == 0));
        check("vec_eng_last", bus.eng_last, 128'(s == vecs[v].nr));
        check("vec_eng_decrypt", bus.eng_decrypt, vecs[v].dec);
        check("vec_eng_keysel", bus.eng_keysel, vecs[v].keysel);
        check("vec_busy", bus.busy, 1);
        check("vec_in_ready", bus.in_ready, 0);
        check("vec_out_valid_early", bus.out_valid, 0);
        // inputs other than the handshake must not disturb the running job
        bus.in_keysel  = 2'($urandom);
        bus.in_decrypt = 1'($urandom);
        bus.in_tag     = 4'($urandom);
        bus.in_data    = {$urandom, $urandom, $urandom, $urandom};
        tick();
      end
      check("vec_out_valid", bus.out_valid, 1);
      check("vec_in_ready_back", bus.in_ready, 1);
      check("vec_busy_done", bus.busy, 0);
      check("vec_out_data", bus.out_data, vecs[v].exp_data);
      check("vec_out_tag", bus.out_tag, vecs[v].tag);
      check("vec_out_decrypt", bus.out_decrypt, vecs[v].dec);
      check("vec_jobs_done", bus.jobs_done, 128'(v + 1));
      check("vec_idle_key_idx", bus.eng_key_idx, 0);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check("vec_popped", bus.out_valid, 0);
    end

    // full FIFO: fifth job stalls, then pushes on the same edge the head pops
    do_reset();
    for (int t = 0; t < 5; t++) issue(2'b00, 1'b0, 128'(t * 256), 4'(t));
    for (int k = 0; k < 14; k++) tick();
    check("stall_busy", bus.busy, 1);
    check("stall_in_ready", bus.in_ready, 0);
    check("stall_out_valid", bus.out_valid, 1);
    check("stall_eng_round", bus.eng_round, 10);
    check("stall_eng_last", bus.eng_last, 1);
    check("stall_eng_state", bus.eng_state, 128'h40A);
    check("stall_head_tag", bus.out_tag, 0);
    check("stall_jobs_done", bus.jobs_done, 4);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("stall_release_busy", bus.busy, 0);
    check("stall_release_ready", bus.in_ready, 1);
    check("stall_release_jobs", bus.jobs_done, 5);
    check("stall_release_head", bus.out_tag, 1);
    bus.out_ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      check("drain_valid", bus.out_valid, 1);
      check("drain_tag", bus.out_tag, 128'(k));
      check("drain_data", bus.out_data, 128'(k * 256 + 11));
      tick();
    end
    check("drain_empty", bus.out_valid, 0);
    bus.out_ready = 1'b0;

    // reset in the middle of a job with results pending
    do_reset();
    issue(2'b00, 1'b0, 128'h1, 4'd1);
    issue(2'b01, 1'b1, 128'h2, 4'd2);
    issue(2'b10, 1'b0, 128'h3, 4'd3);
    begin
      int n;
      n = 0;
      while (bus.eng_round != 4'd5 && n < 40) begin
        tick();
        n++;
      end
      check("rstmid_wait_timeout", 128'(n >= 40), 0);
    end
    check("rstmid_pending", bus.out_valid, 1);
    check("rstmid_jobs_before", bus.jobs_done, 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstmid_out_valid", bus.out_valid, 0);
    check("rstmid_busy", bus.busy, 0);
    check("rstmid_in_ready", bus.in_ready, 1);
    check("rstmid_jobs_done", bus.jobs_done, 0);
    check("rstmid_eng_round", bus.eng_round, 0);
    issue(2'b00, 1'b0, 128'h55, 4'd6);
    for (int k = 0; k < 11; k++) tick();
    check("rstmid_next_valid", bus.out_valid, 1);
    check("rstmid_next_data", bus.out_data, 128'h60);
    check("rstmid_next_tag", bus.out_tag, 6);
    check("rstmid_next_jobs", bus.jobs_done, 1);

    // 17 back-to-back jobs: accept spacing and counter wrap (4-bit counter)
    do_reset();
    bus.out_ready  = 1'b1;
    bus.in_keysel  = 2'b00;
    bus.in_decrypt = 1'b0;
    bus.in_data    = 128'h7;
    bus.in_tag     = 4'd8;
    bus.in_valid   = 1'b1;
    acc_cyc.delete();
    for (int k = 0; k < 17 * 12 + 40 && acc_cyc.size() < 17; k++) begin
      if (bus.in_ready) begin
        if (acc_cyc.size() == 16) check("wrap_jobs_at_16", bus.jobs_done, 0);
        acc_cyc.push_back(cyc);
      end
      tick();
    end
    bus.in_valid = 1'b0;
    check("wrap_accept_count", 128'(acc_cyc.size()), 17);
    for (int k = 1; k < acc_cyc.size(); k++)
      check("wrap_spacing", 128'(acc_cyc[k] - acc_cyc[k-1]), 12);
    for (int k = 0; k < 12; k++) tick();
    check("wrap_jobs_done", bus.jobs_done, 1);
    bus.out_ready = 1'b0;

    // randomized traffic against a cycle-level queue model
    do_reset();
    q.delete();
    m_done = 0;
    m_pend = 1'b0;
    m_start = 0;
    m_nr = 10;
    for (int j = 0; j < 1500; j++) begin
      bit was_pend;
      bit pop;
      bit push;
      int r;
      check("rnd_in_ready", bus.in_ready, 128'(!m_pend));
      check("rnd_busy", bus.busy, 128'(m_pend));
      check("rnd_out_valid", bus.out_valid, 128'(q.size() != 0));
      check("rnd_jobs_done", bus.jobs_done, 128'(m_done % 16));
      if (q.size() != 0) begin
        check("rnd_out_data", bus.out_data, q[0].data);
        check("rnd_out_tag", bus.out_tag, q[0].tag);
        check("rnd_out_decrypt", bus.out_decrypt, q[0].dec);
      end
      if (m_pend) begin
        r = (j - m_start > m_nr) ? m_nr : j - m_start;
        check("rnd_eng_round", bus.eng_round, 128'(r));
        check("rnd_key_idx", bus.eng_key_idx, 128'(m_ent.dec ? m_nr - r : r));
      end else begin
        check("rnd_idle_round", bus.eng_round, 0);
      end
      bus.in_valid   = ($urandom_range(0, 3) != 0);
      bus.in_keysel  = 2'($urandom);
      bus.in_decrypt = 1'($urandom);
      bus.in_tag     = 4'($urandom);
      bus.in_data    = {$urandom, $urandom, $urandom, $urandom};
      bus.out_ready  = ($urandom_range(0, 2) == 0);
      was_pend = m_pend;
      pop  = (q.size() != 0) && bus.out_ready;
      push = m_pend && (j >= m_start + m_nr) && (q.size() < OUT_DEPTH || pop);
      if (pop) void'(q.pop_front());
      if (push) begin
        q.push_back(m_ent);
        m_done++;
        m_pend = 1'b0;
      end
      if (!was_pend && bus.in_valid) begin
        m_pend      = 1'b1;
        m_start     = j + 1;
        m_nr        = nr_of(bus.in_keysel);
        m_ent.data  = bus.in_data + 128'(m_nr + 1);
        m_ent.tag   = bus.in_tag;
        m_ent.dec   = bus.in_decrypt;
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
